lemon_ifu: RTL and testbench
============================

LEMON_IFU -- requirements
Module: lemon_ifu

Interface
REQ-001 Parameter: RESET_PC, default 32'h8000_0000, address of the first instruction fetched after reset.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: imem_req_valid  output  1  instruction-memory read request valid.
REQ-005 Port: imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 Port: imem_req_addr  output  32  word-aligned fetch address.
REQ-007 Port: imem_rsp_valid  input  1  read data valid.
REQ-008 Port: imem_rsp_data  input  32  fetched instruction word.
REQ-009 Port: inst_valid  output  1  inst/inst_pc hold a fetched instruction for the decoder.
REQ-010 Port: inst_ready  input  1  decoder/execute consumes the instruction this cycle.
REQ-011 Port: inst  output  32  instruction word to decoder.
REQ-012 Port: inst_pc  output  32  address of inst.
REQ-013 Port: redirect_valid  input  1  next PC comes from redirect_pc (jal/jalr, pc_sel_alu).
REQ-014 Port: redirect_pc  input  32  branch/jump target.
REQ-015 Port: halt  input  1  current instruction is ebreak; stop fetching.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, HOLD, HALT; exactly one request outstanding at any time.
REQ-017 IDLE -> REQ unconditionally on the first clock edge after rst_n deasserts.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; addr stays stable until imem_req_ready; REQ -> WAIT on req_valid && req_ready.
REQ-019 WAIT: imem_req_valid=0; on imem_rsp_valid, capture imem_rsp_data into inst and pc into inst_pc; WAIT -> HOLD.
REQ-020 Same-cycle response (imem_rsp_valid in the cycle after acceptance) is legal; minimum fetch latency is reset-release +1 cycle to first request and response +1 cycle to inst_valid.
REQ-021 imem_rsp_valid outside WAIT is ignored; it changes no state.
REQ-022 HOLD: inst_valid=1; inst and inst_pc are stable until inst_valid && inst_ready.
REQ-023 On the HOLD handshake, priority: halt -> HALT (pc unchanged); else redirect_valid -> pc=redirect_pc, go REQ; else pc=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), go REQ.
REQ-024 redirect_valid and halt are sampled only on the HOLD handshake cycle and ignored in all other states.
REQ-025 HALT: inst_valid=0, imem_req_valid=0; HALT is exited only by reset.
REQ-026 Next-instruction request issues the cycle after the HOLD handshake; back-to-back throughput is one instruction per 3 cycles with zero-wait memory.

Reset
REQ-027 While rst_n=0: state=IDLE, pc=RESET_PC, imem_req_valid=0, inst_valid=0, inst=32'h0, inst_pc=32'h0, independent of clk.
REQ-028 Reset asserted mid-WAIT discards the outstanding request; a late response after reset release arrives outside WAIT and is ignored under REQ-021.

Configuration
REQ-029 Macro IFU_MISALIGN_CHK_EN: when defined, adds output fetch_misalign (1 bit, reset 0) and checks redirect_pc[1:0] on each redirect.
REQ-030 With IFU_MISALIGN_CHK_EN defined, a redirect with redirect_pc[1:0]!=0 goes to HALT with fetch_misalign=1, held until reset; no request is issued.
REQ-031 Without IFU_MISALIGN_CHK_EN, no fetch_misalign port exists and pc takes {redirect_pc[31:2],2'b00}.

Verification
REQ-032 Reset release, memory always ready, zero wait -> first imem_req_addr=32'h8000_0000 one cycle after release; inst_pc sequence 8000_0000, 8000_0004, 8000_0008.
REQ-033 imem_req_ready held low 5 cycles -> imem_req_valid stays 1 and imem_req_addr stays constant for all 5 cycles.
REQ-034 inst_ready held low 4 cycles in HOLD -> inst and inst_pc unchanged, no new request issued.
REQ-035 Handshake at pc 8000_0010 with redirect_valid=1, redirect_pc=8000_0100 -> next imem_req_addr=8000_0100; with halt=1 as well -> HALT, no further requests.
REQ-036 Spurious imem_rsp_valid in REQ/HOLD, plus rst_n pulsed low during WAIT -> no state change from the spurious response; after reset, fetch restarts at RESET_PC.
REQ-037 With IFU_MISALIGN_CHK_EN, redirect_pc=8000_0102 -> fetch_misalign=1, imem_req_valid stays 0.

Source files
------------

// File: rtl/lemon_ifu.sv
// Lemon instruction fetch unit: one outstanding imem read, single-entry hold register for the decoder.
// Optional build macro IFU_MISALIGN_CHK_EN adds fetch_misalign and halts on misaligned redirect targets.
module lemon_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        capture;
`ifdef IFU_MISALIGN_CHK_EN
    logic        misalign_set;
`endif

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == HOLD);

    // Redirect and halt only matter on the cycle the decoder takes the held instruction.
    always_comb begin
        next_state = state;
        pc_next    = pc;
        capture    = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        misalign_set = 1'b0;
`endif
        case (state)
            IDLE: next_state = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    if (halt) begin
                        next_state = HALT;
                    end else if (redirect_valid) begin
`ifdef IFU_MISALIGN_CHK_EN
                        if (redirect_pc[1:0] != 2'b00) begin
                            misalign_set = 1'b1;
                            next_state   = HALT;
                        end else begin
                            pc_next    = redirect_pc;
                            next_state = REQ;
                        end
`else
                        pc_next    = redirect_pc & 32'hFFFF_FFFC;
                        next_state = REQ;
`endif
                    end else begin
                        pc_next    = pc + 32'd4;
                        next_state = REQ;
                    end
                end
            end
            HALT: next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            inst    <= 32'h0;
            inst_pc <= 32'h0;
        end else begin
            state <= next_state;
            pc    <= pc_next;
            if (capture) begin
                inst    <= imem_rsp_data;
                inst_pc <= pc;
            end
        end
    end

`ifdef IFU_MISALIGN_CHK_EN
    // Sticky until reset so software can see why fetch stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_misalign <= 1'b0;
        end else if (misalign_set) begin
            fetch_misalign <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lemon_ifu.sv
// Self-checking bench for lemon_ifu: cycle vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level fetch model.
module tb_lemon_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    int errors = 0;
    int checks = 0;

    lemon_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        inst_ready;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
        logic        halt;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_inst_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_inst_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_row(input logic rdy, input logic rv, input logic [31:0] rd, input logic ir,
                           input logic rdv, input logic [31:0] rpc, input logic h,
                           input logic erv, input logic [31:0] eaddr, input logic eiv,
                           input logic [31:0] einst, input logic [31:0] epc);
        vec_t v;
        v.req_ready = rdy;  v.rsp_valid = rv;  v.rsp_data = rd;  v.inst_ready = ir;
        v.redirect_valid = rdv;  v.redirect_pc = rpc;  v.halt = h;
        v.exp_req_valid = erv;  v.exp_req_addr = eaddr;  v.exp_inst_valid = eiv;
        v.exp_inst = einst;  v.exp_inst_pc = epc;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        imem_req_ready = v.req_ready;
        imem_rsp_valid = v.rsp_valid;
        imem_rsp_data  = v.rsp_data;
        inst_ready     = v.inst_ready;
        redirect_valid = v.redirect_valid;
        redirect_pc    = v.redirect_pc;
        halt           = v.halt;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        check_eq($sformatf("row%0d_req_valid", idx), {31'b0, imem_req_valid}, {31'b0, v.exp_req_valid});
        if (v.exp_req_valid)
            check_eq($sformatf("row%0d_req_addr", idx), imem_req_addr, v.exp_req_addr);
        check_eq($sformatf("row%0d_inst_valid", idx), {31'b0, inst_valid}, {31'b0, v.exp_inst_valid});
        if (v.exp_inst_valid) begin
            check_eq($sformatf("row%0d_inst", idx), inst, v.exp_inst);
            check_eq($sformatf("row%0d_inst_pc", idx), inst_pc, v.exp_inst_pc);
        end
    endtask

    task automatic clear_inputs();
        imem_req_ready = 1'b0;  imem_rsp_valid = 1'b0;  imem_rsp_data = 32'h0;
        inst_ready = 1'b0;  redirect_valid = 1'b0;  redirect_pc = 32'h0;  halt = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
        check_eq({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'h0);
        check_eq({tag, "_inst"}, inst, 32'h0);
        check_eq({tag, "_inst_pc"}, inst_pc, 32'h0);
`ifdef IFU_MISALIGN_CHK_EN
        check_eq({tag, "_misalign"}, {31'b0, fetch_misalign}, 32'h0);
`endif
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset(input string tag);
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values(tag);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Transaction-level model state for the random phase.
    logic [31:0] exp_pc;
    bit          want_req, outstanding, holding, halted, first_cycle, exp_mis, wrap_done;
    int          delay, delivered, stall;

    initial begin
        localparam logic [31:0] A = RESET_PC;

        // Reset, fetch stream, stalls, redirect, halt.
        add_row(1,0,32'h0,        0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);
        add_row(1,1,32'hDEAD_BEEF,0,0,32'h0,0,        1,A,0,32'h0,32'h0);
        add_row(1,1,32'h1111_1111,0,1,32'hFFFF_FFF0,1,0,32'h0,0,32'h0,32'h0);
        add_row(1,0,32'h0,        1,0,32'h0,0,        0,32'h0,1,32'h1111_1111,A);
        add_row(1,0,32'h0,        0,0,32'h0,0,        1,A+4,0,32'h0,32'h0);
        add_row(1,1,32'h2222_2222,0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);
        add_row(0,1,32'hBAD0_BAD0,0,0,32'h0,0,        0,32'h0,1,32'h2222_2222,A+4);
        for (int i = 0; i < 3; i++)
            add_row(0,0,32'h0,    0,1,32'h40,1,       0,32'h0,1,32'h2222_2222,A+4);
        add_row(1,0,32'h0,        1,0,32'h0,0,        0,32'h0,1,32'h2222_2222,A+4);
        for (int i = 0; i < 5; i++)
            add_row(0,0,32'h0,    0,0,32'h0,0,        1,A+8,0,32'h0,32'h0);
        add_row(1,0,32'h0,        0,0,32'h0,0,        1,A+8,0,32'h0,32'h0);
        add_row(0,0,32'h0,        0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);
        add_row(0,1,32'h3333_3333,0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);
        add_row(0,0,32'h0,        1,1,A+32'h10,0,     0,32'h0,1,32'h3333_3333,A+8);
        add_row(1,0,32'h0,        0,1,32'hFFFF_FFF0,1,1,A+32'h10,0,32'h0,32'h0);
        add_row(1,1,32'h4444_4444,0,0,32'h0,1,        0,32'h0,0,32'h0,32'h0);
        add_row(1,0,32'h0,        1,1,32'h8000_0100,0,0,32'h0,1,32'h4444_4444,A+32'h10);
        add_row(1,0,32'h0,        0,0,32'h0,0,        1,32'h8000_0100,0,32'h0,32'h0);
        add_row(1,1,32'h5555_5555,0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);
        add_row(1,0,32'h0,        1,1,32'h1234_5678,1,0,32'h0,1,32'h5555_5555,32'h8000_0100);
        add_row(1,1,32'h6666_6666,1,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);
        add_row(1,0,32'h0,        1,1,32'h0,0,        0,32'h0,0,32'h0,32'h0);
        add_row(1,0,32'h0,        0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);

        do_reset("reset0");
        foreach (vecs[i]) begin
            check_output(vecs[i], i);
            apply_stimulus(vecs[i]);
            @(negedge clk);
        end

        // Reset pulsed mid-WAIT, then a late response must be ignored.
        do_reset("reset1");
        imem_req_ready = 1'b1;
        @(negedge clk);
        check_eq("midwait_req", {31'b0, imem_req_valid}, 32'h1);
        @(negedge clk);
        check_eq("midwait_wait", {31'b0, imem_req_valid}, 32'h0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        check_eq("async_reset_addr", imem_req_addr, RESET_PC);
        @(negedge clk);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("restart_req", {31'b0, imem_req_valid}, 32'h1);
        check_eq("restart_addr", imem_req_addr, RESET_PC);
        check_eq("late_rsp_ignored", {31'b0, inst_valid}, 32'h0);
        @(negedge clk);
        check_eq("late_rsp_still_req", {31'b0, imem_req_valid}, 32'h1);
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h7777_7777;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check_eq("restart_inst", inst, 32'h7777_7777);
        check_eq("restart_inst_pc", inst_pc, RESET_PC);

        // Misaligned redirect target.
        do_reset("reset2");
        imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1357_9BDF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check_eq("mis_hold_valid", {31'b0, inst_valid}, 32'h1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        @(negedge clk);
        clear_inputs();
        imem_req_ready = 1'b1;
`ifdef IFU_MISALIGN_CHK_EN
        for (int i = 0; i < 4; i++) begin
            check_eq("mis_flag", {31'b0, fetch_misalign}, 32'h1);
            check_eq("mis_no_req", {31'b0, imem_req_valid}, 32'h0);
            check_eq("mis_no_inst", {31'b0, inst_valid}, 32'h0);
            @(negedge clk);
        end
`else
        check_eq("mis_trunc_req", {31'b0, imem_req_valid}, 32'h1);
        check_eq("mis_trunc_addr", imem_req_addr, 32'h8000_0100);
`endif

        // Randomized traffic against the fetch model.
        wrap_done = 0;
        for (int ep = 0; ep < 4; ep++) begin
            do_reset("reset_rnd");
            exp_pc = RESET_PC;
            want_req = 0; outstanding = 0; holding = 0; halted = 0;
            first_cycle = 1; exp_mis = 0; delay = 0; delivered = 0; stall = 0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                check_eq("rnd_req_valid", {31'b0, imem_req_valid}, {31'b0, want_req});
                if (want_req)
                    check_eq("rnd_req_addr", imem_req_addr, exp_pc);
                check_eq("rnd_inst_valid", {31'b0, inst_valid}, {31'b0, holding});
                if (holding) begin
                    check_eq("rnd_inst", inst, mem_word(exp_pc));
                    check_eq("rnd_inst_pc", inst_pc, exp_pc);
                end
`ifdef IFU_MISALIGN_CHK_EN
                check_eq("rnd_misalign", {31'b0, fetch_misalign}, {31'b0, exp_mis});
`endif
                if (halted && stall > 5) break;
                if (!halted && stall > 60) begin
                    check_eq("rnd_progress_timeout", 32'h1, 32'h0);
                    break;
                end
                if (delivered >= 40) break;

                imem_req_ready = ($urandom_range(0, 3) != 0);
                if (outstanding && delay == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(exp_pc);
                end else begin
                    imem_rsp_valid = !outstanding && ($urandom_range(0, 5) == 0);
                    imem_rsp_data  = $urandom;
                    if (outstanding) delay--;
                end
                inst_ready     = ($urandom_range(0, 2) != 0);
                redirect_valid = ($urandom_range(0, 3) == 0);
                if (!wrap_done)
                    redirect_pc = 32'hFFFF_FFFC;
                else if ($urandom_range(0, 3) == 0)
                    redirect_pc = $urandom;
                else
                    redirect_pc = $urandom & 32'hFFFF_FFFC;
                halt = ($urandom_range(0, 24) == 0);

                stall++;
                if (first_cycle) begin
                    first_cycle = 0;
                    want_req = 1;
                end else if (want_req && imem_req_ready) begin
                    want_req = 0;
                    outstanding = 1;
                    delay = $urandom_range(0, 2);
                    stall = 0;
                end else if (outstanding && imem_rsp_valid) begin
                    outstanding = 0;
                    holding = 1;
                end else if (holding && inst_ready) begin
                    holding = 0;
                    delivered++;
                    stall = 0;
                    if (halt) begin
                        halted = 1;
                    end else if (redirect_valid) begin
`ifdef IFU_MISALIGN_CHK_EN
                        if (redirect_pc % 4 != 0) begin
                            halted = 1;
                            exp_mis = 1;
                        end else begin
                            exp_pc = redirect_pc;
                            want_req = 1;
                        end
`else
                        exp_pc = redirect_pc - (redirect_pc % 4);
                        want_req = 1;
`endif
                        if (redirect_pc == 32'hFFFF_FFFC && want_req) wrap_done = 1;
                    end else begin
                        exp_pc = exp_pc + 32'd4;
                        want_req = 1;
                    end
                end
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
